regwrite_arbiter: RTL and testbench
===================================

# regwrite_arbiter

Shares the single write port of the 32×32 register file between two writeback sources: the ALU result path and the memory-load path. Each source hands over (address, data) with a valid/ready handshake into a one-entry holding buffer. The arbiter grants at most one buffered write per cycle to the register file, alternating fairly between sources and preserving program order for same-register writes. It exports a per-register pending mask for hazard detection.

## Interface
- No parameters; data width 32, address width 5, fixed.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `alu_valid`  in  1  ALU write request.
- `alu_addr`  in  5  ALU destination register.
- `alu_data`  in  32  ALU write value.
- `alu_ready`  out  1  ALU request accepted this cycle when `alu_valid` is also high.
- `mem_valid`, `mem_addr`, `mem_data`, `mem_ready`  as ALU set, for the load path.
- `rf_wen`  out  1  to register file `regWflag`.
- `rf_waddr`  out  5  to register file `regWaddr`.
- `rf_wdata`  out  32  to register file `data`.
- `pending`  out  32  bit r = 1 while any buffer holds a write to register r; bit 0 always 0.

## Operation
- State per source: `full`, `addr[4:0]`, `data[31:0]`. Shared state: `rr` (round-robin pointer: 0 = ALU favoured, 1 = MEM favoured) and `mem_older` (age bit, meaningful only when both buffers are full).
- Handshake: `x_ready = !x_full || grant_x`. It is combinational from buffer state and grant only, with no path from `x_valid`. Accept = `x_valid && x_ready`.
- Register 0: an accepted request with addr 0 completes the handshake but is not buffered; `full` is left unchanged (cleared if drained). There is never a write to register 0.
- Grant (combinational, at most one):
  - Neither full → no grant; `rf_wen` = 0.
  - One full → grant it.
  - Both full, same addr → grant the older: MEM if `mem_older`, else ALU.
  - Both full, different addr → grant per `rr`.
- Drive: `rf_wen` = 1, with `rf_waddr`/`rf_wdata` from the granted buffer. When there is no grant, `rf_waddr`/`rf_wdata` are 0.
- On a grant: `rr` points to the non-granted source; the granted buffer clears unless refilled the same cycle.
- Age:
  - One buffer loads while the other stays full → the loaded one is younger. `mem_older` = 1 if ALU loaded, 0 if MEM loaded.
  - Both load in the same cycle → MEM is older, because a load precedes the ALU op in program order.
- `pending`: OR of decoded addresses of full buffers, with bit 0 forced to 0.

## Timing
- Reset values: all `full` = 0, `rr` = 0, `mem_older` = 0, `rf_wen` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `pending` = 0. Both readies read 1 in the first cycle after reset.
- Latency: handshake in cycle N → earliest `rf_wen` in cycle N+1. The register file captures the value at the end of N+1.
- Throughput:
  - One source alone sustains 1 write/cycle (drain and refill in the same cycle).
  - Both sources together: 1 write/cycle total, each at 1/2 under contention.
- Simultaneous accept and drain of the same buffer → the new entry replaces the drained one; `full` stays 1.
- Reset during an active cycle discards buffered writes. `rf_wen` = 0 in the cycle after reset is asserted.
- No other fill/drain ordering exists; buffers are one deep and never overflow because `ready` gates acceptance.

## Test plan
- Reset and idle:
  - Assert `reset` for 2 cycles with both valids high → `rf_wen` = 0 and `pending` = 0 throughout.
  - First cycle after reset → both readies = 1.
- Single source streaming: ALU valid every cycle with addr 8,9,10, data 0xA,0xB,0xC → `rf_wen` high for 3 consecutive cycles starting 1 cycle after the first handshake, with pairs (8,0xA),(9,0xB),(10,0xC); `alu_ready` stays 1.
- Contention, different registers: both sources valid continuously, ALU addr 5, MEM addr 6 → writes alternate ALU, MEM, ALU, … (`rr` = 0 at reset); each source's ready is high every other cycle.
- Same-register ordering:
  - MEM and ALU both target reg 12 in the same cycle (MEM 0x111, ALU 0x222) → write 0x111 then 0x222; final reg 12 = 0x222.
  - Repeat with ALU accepted one cycle before MEM → ALU first.
- Register 0: ALU request addr 0, data 0xFFFFFFFF → handshake completes, `rf_wen` stays 0, `pending[0]` = 0.
- Reset mid-operation: both buffers full (regs 3 and 4) and `reset` asserted → next cycle `rf_wen` = 0 and `pending` = 0; neither register is written.

Source files
------------

// File: rtl/regwrite_arbiter_if.sv
// Purpose: bundles two writeback request channels and the register-file write port.
// Latency: none, wires only.
// Backpressure: each request channel uses valid/ready; the register-file port never stalls.
interface regwrite_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  // Writeback sources plus register-file consumer.
  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  rf_wen, rf_waddr, rf_wdata, pending
  );

  // The arbiter.
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output rf_wen, rf_waddr, rf_wdata, pending
  );
endinterface

// File: rtl/regwrite_arbiter.sv
// Purpose: two one-entry writeback buffers (ALU, MEM) share the register-file write port.
// Latency: handshake in cycle N gives the earliest rf_wen in cycle N+1.
// Backpressure: ready = buffer empty or being drained this cycle; no path from valid.
module regwrite_arbiter (
  input  logic               clk,
  input  logic               reset,
  regwrite_arbiter_if.slave  bus
);

  logic        alu_full_q, alu_full_d;
  logic [4:0]  alu_addr_q, alu_addr_d;
  logic [31:0] alu_data_q, alu_data_d;
  logic        mem_full_q, mem_full_d;
  logic [4:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        rr_q, rr_d;               // 0: ALU favoured, 1: MEM favoured
  logic        mem_older_q, mem_older_d; // valid only while both buffers are full

  logic        grant_alu;
  logic        grant_mem;
  logic        alu_rdy;
  logic        mem_rdy;
  logic        alu_load;
  logic        mem_load;
  logic [31:0] pend;

  // Pick at most one buffer: age decides same-register conflicts so program
  // order holds, round-robin decides otherwise. Nothing is granted while in
  // reset so buffered writes being discarded never reach the register file.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!reset) begin
      if (alu_full_q && mem_full_q) begin
        if (alu_addr_q == mem_addr_q) begin
          grant_mem = mem_older_q;
          grant_alu = !mem_older_q;
        end else begin
          grant_mem = rr_q;
          grant_alu = !rr_q;
        end
      end else begin
        grant_alu = alu_full_q;
        grant_mem = mem_full_q;
      end
    end
  end

  // Handshakes, write-port drive and the hazard mask.
  always_comb begin
    alu_rdy = !alu_full_q || grant_alu;
    mem_rdy = !mem_full_q || grant_mem;

    bus.alu_ready = alu_rdy;
    bus.mem_ready = mem_rdy;
    bus.rf_wen    = grant_alu || grant_mem;
    bus.rf_waddr  = 5'd0;
    bus.rf_wdata  = 32'd0;
    if (grant_alu) begin
      bus.rf_waddr = alu_addr_q;
      bus.rf_wdata = alu_data_q;
    end else if (grant_mem) begin
      bus.rf_waddr = mem_addr_q;
      bus.rf_wdata = mem_data_q;
    end

    pend = 32'd0;
    if (alu_full_q) pend[alu_addr_q] = 1'b1;
    if (mem_full_q) pend[mem_addr_q] = 1'b1;
    pend[0] = 1'b0;
    bus.pending = pend;
  end

  // Buffer fill/drain, round-robin pointer and relative age.
  always_comb begin
    // Writes to r0 complete the handshake but are dropped here.
    alu_load = bus.alu_valid && alu_rdy && (bus.alu_addr != 5'd0);
    mem_load = bus.mem_valid && mem_rdy && (bus.mem_addr != 5'd0);

    alu_full_d = alu_full_q;
    alu_addr_d = alu_addr_q;
    alu_data_d = alu_data_q;
    if (grant_alu) alu_full_d = 1'b0;
    if (alu_load) begin
      alu_full_d = 1'b1;
      alu_addr_d = bus.alu_addr;
      alu_data_d = bus.alu_data;
    end

    mem_full_d = mem_full_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (grant_mem) mem_full_d = 1'b0;
    if (mem_load) begin
      mem_full_d = 1'b1;
      mem_addr_d = bus.mem_addr;
      mem_data_d = bus.mem_data;
    end

    rr_d = rr_q;
    if (grant_alu)      rr_d = 1'b1;
    else if (grant_mem) rr_d = 1'b0;

    // A load issues before the ALU op it races, so a simultaneous fill makes
    // MEM the older entry; otherwise the freshly loaded entry is the younger.
    mem_older_d = mem_older_q;
    if (alu_load && mem_load)
      mem_older_d = 1'b1;
    else if (alu_load && mem_full_q && !grant_mem)
      mem_older_d = 1'b1;
    else if (mem_load && alu_full_q && !grant_alu)
      mem_older_d = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_full_q  <= 1'b0;
      alu_addr_q  <= 5'd0;
      alu_data_q  <= 32'd0;
      mem_full_q  <= 1'b0;
      mem_addr_q  <= 5'd0;
      mem_data_q  <= 32'd0;
      rr_q        <= 1'b0;
      mem_older_q <= 1'b0;
    end else begin
      alu_full_q  <= alu_full_d;
      alu_addr_q  <= alu_addr_d;
      alu_data_q  <= alu_data_d;
      mem_full_q  <= mem_full_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      rr_q        <= rr_d;
      mem_older_q <= mem_older_d;
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Purpose: self-checking bench for regwrite_arbiter (vector table, hand sequences, random vs model).
// Latency: outputs are sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: the model predicts ready from its own view of buffer occupancy.
module tb_regwrite_arbiter;
  logic clk = 1'b0;
  logic reset;
  regwrite_arbiter_if bus();

  regwrite_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each source holds a list of pending writes stamped with
  // a global issue number; the register file is a plain array.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          seq;
  } slot_t;

  slot_t       alu_slot[$];
  slot_t       mem_slot[$];
  int          seq_cnt = 0;
  bit          last_was_alu = 1'b0;
  bit          m_ga, m_gm;
  bit          e_wen, e_ar, e_mr;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;
  logic [31:0] e_pend;
  logic [31:0] dut_regs [32];
  int          w34 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_comb();
    m_ga = 1'b0;
    m_gm = 1'b0;
    if (!reset) begin
      if (alu_slot.size() != 0 && mem_slot.size() != 0) begin
        if (alu_slot[0].addr == mem_slot[0].addr)
          m_gm = (mem_slot[0].seq < alu_slot[0].seq);
        else
          m_gm = last_was_alu;
        m_ga = !m_gm;
      end else begin
        m_ga = (alu_slot.size() != 0);
        m_gm = (mem_slot.size() != 0);
      end
    end
    e_wen = m_ga || m_gm;
    e_wa  = 5'd0;
    e_wd  = 32'd0;
    if (m_ga) begin e_wa = alu_slot[0].addr; e_wd = alu_slot[0].data; end
    if (m_gm) begin e_wa = mem_slot[0].addr; e_wd = mem_slot[0].data; end
    e_ar = (alu_slot.size() == 0) || m_ga;
    e_mr = (mem_slot.size() == 0) || m_gm;
    e_pend = 32'd0;
    if (alu_slot.size() != 0) e_pend = e_pend | (32'd1 << alu_slot[0].addr);
    if (mem_slot.size() != 0) e_pend = e_pend | (32'd1 << mem_slot[0].addr);
  endtask

  task automatic model_seq();
    slot_t s;
    if (reset) begin
      alu_slot.delete();
      mem_slot.delete();
      last_was_alu = 1'b0;
    end else begin
      if (m_ga) begin alu_slot.delete(0); last_was_alu = 1'b1; end
      if (m_gm) begin mem_slot.delete(0); last_was_alu = 1'b0; end
      // MEM gets the lower issue number when both arrive together.
      if (bus.mem_valid && e_mr && bus.mem_addr != 5'd0) begin
        s.addr = bus.mem_addr; s.data = bus.mem_data; s.seq = seq_cnt++;
        mem_slot.push_back(s);
      end
      if (bus.alu_valid && e_ar && bus.alu_addr != 5'd0) begin
        s.addr = bus.alu_addr; s.data = bus.alu_data; s.seq = seq_cnt++;
        alu_slot.push_back(s);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_comb();
    if (bus.rf_wen === 1'b1) begin
      dut_regs[bus.rf_waddr] = bus.rf_wdata;
      if (bus.rf_waddr == 5'd3 || bus.rf_waddr == 5'd4) w34++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic model_check();
    chk("rf_wen",    {31'd0, bus.rf_wen},    {31'd0, e_wen});
    chk("rf_waddr",  {27'd0, bus.rf_waddr},  {27'd0, e_wa});
    chk("rf_wdata",  bus.rf_wdata,           e_wd);
    chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, e_ar});
    chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, e_mr});
    chk("pending",   bus.pending,            e_pend);
  endtask

  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
  endtask

  typedef struct {
    bit          av; logic [4:0] aa; logic [31:0] ad;
    bit          mv; logic [4:0] ma; logic [31:0] md;
    bit          wen; logic [4:0] wa; logic [31:0] wd;
    bit          ar; bit mr; logic [31:0] pend;
  } vec_t;

  function automatic vec_t mk(bit av, logic [4:0] aa, logic [31:0] ad,
                              bit mv, logic [4:0] ma, logic [31:0] md,
                              bit wen, logic [4:0] wa, logic [31:0] wd,
                              bit ar, bit mr, logic [31:0] pend);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.wen = wen; v.wa = wa; v.wd = wd; v.ar = ar; v.mr = mr; v.pend = pend;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    for (int i = 0; i < 32; i++) dut_regs[i] = 32'd0;

    //             av aa  ad          mv ma  md          wen wa  wd          ar mr pend
    // contention, different registers: ALU first after reset, then alternate
    tbl[0]  = mk(1, 5,  32'h51,      1, 6,  32'h61,      0, 0,  32'h0,       1, 1, 32'h0);
    tbl[1]  = mk(1, 5,  32'h52,      1, 6,  32'h62,      1, 5,  32'h51,      1, 0, 32'h60);
    tbl[2]  = mk(1, 5,  32'h53,      1, 6,  32'h62,      1, 6,  32'h61,      0, 1, 32'h60);
    tbl[3]  = mk(1, 5,  32'h53,      1, 6,  32'h63,      1, 5,  32'h52,      1, 0, 32'h60);
    tbl[4]  = mk(0, 0,  32'h0,       1, 6,  32'h63,      1, 6,  32'h62,      0, 1, 32'h60);
    tbl[5]  = mk(0, 0,  32'h0,       0, 0,  32'h0,       1, 5,  32'h53,      1, 0, 32'h60);
    tbl[6]  = mk(0, 0,  32'h0,       0, 0,  32'h0,       1, 6,  32'h63,      1, 1, 32'h40);
    tbl[7]  = mk(0, 0,  32'h0,       0, 0,  32'h0,       0, 0,  32'h0,       1, 1, 32'h0);
    // single-source streaming
    tbl[8]  = mk(1, 8,  32'hA,       0, 0,  32'h0,       0, 0,  32'h0,       1, 1, 32'h0);
    tbl[9]  = mk(1, 9,  32'hB,       0, 0,  32'h0,       1, 8,  32'hA,       1, 1, 32'h100);
    tbl[10] = mk(1, 10, 32'hC,       0, 0,  32'h0,       1, 9,  32'hB,       1, 1, 32'h200);
    tbl[11] = mk(0, 0,  32'h0,       0, 0,  32'h0,       1, 10, 32'hC,       1, 1, 32'h400);
    tbl[12] = mk(0, 0,  32'h0,       0, 0,  32'h0,       0, 0,  32'h0,       1, 1, 32'h0);
    // r0 request dropped; MEM write to r3 leaves ALU favoured
    tbl[13] = mk(1, 0,  32'hFFFFFFFF, 1, 3, 32'h33,      0, 0,  32'h0,       1, 1, 32'h0);
    tbl[14] = mk(0, 0,  32'h0,       0, 0,  32'h0,       1, 3,  32'h33,      1, 1, 32'h8);
    // same register, same cycle: MEM older wins over round-robin
    tbl[15] = mk(1, 12, 32'h222,     1, 12, 32'h111,     0, 0,  32'h0,       1, 1, 32'h0);
    tbl[16] = mk(0, 0,  32'h0,       0, 0,  32'h0,       1, 12, 32'h111,     0, 1, 32'h1000);
    tbl[17] = mk(0, 0,  32'h0,       0, 0,  32'h0,       1, 12, 32'h222,     1, 1, 32'h1000);
    tbl[18] = mk(0, 0,  32'h0,       0, 0,  32'h0,       0, 0,  32'h0,       1, 1, 32'h0);
    // same register, ALU accepted a cycle before MEM
    tbl[19] = mk(1, 12, 32'h333,     1, 7,  32'h77,      0, 0,  32'h0,       1, 1, 32'h0);
    tbl[20] = mk(0, 0,  32'h0,       1, 12, 32'h444,     1, 7,  32'h77,      0, 1, 32'h1080);
    tbl[21] = mk(0, 0,  32'h0,       0, 0,  32'h0,       1, 12, 32'h333,     1, 0, 32'h1000);
    tbl[22] = mk(0, 0,  32'h0,       0, 0,  32'h0,       1, 12, 32'h444,     1, 1, 32'h1000);
    tbl[23] = mk(0, 0,  32'h0,       0, 0,  32'h0,       0, 0,  32'h0,       1, 1, 32'h0);

    // Reset with both sources requesting: nothing buffered, nothing written.
    reset = 1'b1;
    drive(1, 5'd3, 32'hDEAD, 1, 5'd4, 32'hBEEF);
    advance();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("reset_rf_wen", {31'd0, bus.rf_wen}, 32'd0);
      chk("reset_pending", bus.pending, 32'd0);
      advance();
    end
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md);
      sample();
      chk($sformatf("v%0d_rf_wen", i),    {31'd0, bus.rf_wen},    {31'd0, tbl[i].wen});
      chk($sformatf("v%0d_rf_waddr", i),  {27'd0, bus.rf_waddr},  {27'd0, tbl[i].wa});
      chk($sformatf("v%0d_rf_wdata", i),  bus.rf_wdata,           tbl[i].wd);
      chk($sformatf("v%0d_alu_ready", i), {31'd0, bus.alu_ready}, {31'd0, tbl[i].ar});
      chk($sformatf("v%0d_mem_ready", i), {31'd0, bus.mem_ready}, {31'd0, tbl[i].mr});
      chk($sformatf("v%0d_pending", i),   bus.pending,            tbl[i].pend);
      if (i == 18) chk("reg12_after_pair", dut_regs[12], 32'h222);
      advance();
    end
    chk("reg0_never_written", dut_regs[0], 32'd0);

    // Reset while both buffers hold writes to r3 and r4.
    w34 = 0;
    drive(1, 5'd3, 32'h3333, 1, 5'd4, 32'h4444);
    sample();
    model_check();
    advance();
    reset = 1'b1;
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    sample();
    chk("midreset_rf_wen", {31'd0, bus.rf_wen}, 32'd0);
    advance();
    reset = 1'b0;
    sample();
    chk("after_reset_rf_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("after_reset_pending", bus.pending, 32'd0);
    chk("after_reset_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("after_reset_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    advance();
    sample();
    chk("r3_r4_not_written", w34, 32'd0);
    advance();

    // Randomised traffic against the reference model; narrow address range
    // forces frequent same-register conflicts and r0 requests.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      bus.alu_valid = ($urandom_range(0, 9) < 6);
      bus.mem_valid = ($urandom_range(0, 9) < 6);
      bus.alu_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      bus.mem_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      bus.alu_data  = $urandom;
      bus.mem_data  = $urandom;
      sample();
      model_check();
      advance();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
